// File: rtl/stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stall_ctrl_pkg
// Shared definitions for the hazard/stall unit of the 5-stage MIPS core:
//   - datapath-type codes carried in kind[9:5] of every pipeline stage
//   - Tuse/Tnew constants and the per-type lookup functions
//   - hazard(): the producer-side counterpart of the forward unit's fwable
//   - state encoding of the HI/LO busy counter FSM
// ---------------------------------------------------------------------------
package stall_ctrl_pkg;

   typedef enum logic [4:0] {
      DT_NOP      = 5'd0,
      DT_CAL_R    = 5'd1,
      DT_CAL_I    = 5'd2,
      DT_LOAD_M   = 5'd3,
      DT_STORE_M  = 5'd4,
      DT_LOAD_C0  = 5'd5,
      DT_STORE_C0 = 5'd6,
      DT_CMOV     = 5'd7,
      DT_JUMP_I   = 5'd8,
      DT_JUMP_R   = 5'd9,
      DT_BRANCH   = 5'd10
   } dp_type_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // A register read: whether the D instruction reads it at all, and at
   // how many stages after D the value is actually consumed.
   typedef struct packed {
      logic       used;
      logic [1:0] t;
   } tuse_t;

   localparam logic [1:0] TUSE_0 = 2'd0;
   localparam logic [1:0] TUSE_1 = 2'd1;
   localparam logic [1:0] TUSE_2 = 2'd2;
   localparam logic [1:0] TNEW_0 = 2'd0;
   localparam logic [1:0] TNEW_1 = 2'd1;
   localparam logic [1:0] TNEW_2 = 2'd2;

   function automatic tuse_t tuse_rs(input dp_type_e t);
      tuse_t r;
      r.used = 1'b1;
      r.t    = TUSE_1;
      case (t)
         DT_BRANCH, DT_JUMP_R:                                 r.t = TUSE_0;
         DT_CAL_R, DT_CAL_I, DT_LOAD_M, DT_STORE_M, DT_CMOV:   r.t = TUSE_1;
         default:                                              r.used = 1'b0;
      endcase
      return r;
   endfunction

   function automatic tuse_t tuse_rt(input dp_type_e t);
      tuse_t r;
      r.used = 1'b1;
      r.t    = TUSE_1;
      case (t)
         DT_BRANCH, DT_JUMP_R:     r.t = TUSE_0;
         DT_CAL_R, DT_CMOV:        r.t = TUSE_1;
         DT_STORE_M, DT_STORE_C0:  r.t = TUSE_2;
         default:                  r.used = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] tnew_e(input dp_type_e t);
      case (t)
         DT_CAL_R, DT_CAL_I:    return TNEW_1;
         DT_LOAD_M, DT_LOAD_C0: return TNEW_2;
         default:               return TNEW_0;
      endcase
   endfunction

   function automatic logic [1:0] tnew_m(input dp_type_e t);
      case (t)
         DT_LOAD_M, DT_LOAD_C0: return TNEW_1;
         default:               return TNEW_0;
      endcase
   endfunction

   // Forwarding cannot help when the producer needs more cycles than the
   // consumer can wait; $0 is never a real dependency.
   function automatic logic hazard(input logic [4:0] src, input logic [4:0] dst,
                                   input tuse_t tuse, input logic [1:0] tnew);
      return (dst != 5'd0) && (dst == src) && tuse.used && (tnew > tuse.t);
   endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_cnt.sv
// ---------------------------------------------------------------------------
// md_busy_cnt
// HI/LO multiply/divide busy counter. Loads MULT_CYCLES or DIV_CYCLES when a
// mult/div issues from E and counts down to zero; busy is registered.
// Ports:
//   clk    in   core clock
//   reset  in   asynchronous active-high reset (clears the count at once)
//   start  in   mult/multu/div/divu issuing from E this cycle
//   div    in   qualifies start: 1 = divide, 0 = multiply
//   flush  in   pipeline flush; suppresses a load, never aborts a count
//   busy   out  count != 0
// ---------------------------------------------------------------------------
module md_busy_cnt
   import stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic div,
   input  logic flush,
   output logic busy
);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               // A flushed mult/div never reaches HI/LO, so it is not loaded.
               if (start && !flush) begin
                  cnt_q   <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  state_q <= MD_BUSY;
                  busy_q  <= 1'b1;
               end
            end
            MD_BUSY: begin
               // A start here is impossible (D stalls on busy) and is ignored;
               // a flush lets the operation finish architecturally.
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= MD_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= MD_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/stall_ctrl.sv
// ---------------------------------------------------------------------------
// stall_ctrl
// Hazard detection and stall unit for the 5-stage MIPS core. Stalls F/D and
// bubbles E when forwarding cannot deliver an operand in time, or when the
// D instruction touches HI/LO while the multiply/divide unit is busy.
// Optional build macro: STALL_STATS_EN adds the stall_cycles counter port.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   dkind/ekind/mkind   stage kinds; [9:5] datapath type, [4:0] sub-op
//   d_reg1, d_reg2      D rs / rt indices
//   e_regw, m_regw      E / M destination registers
//   d_md                D instruction uses HI/LO
//   e_md_start, e_md_div  mult/div issuing from E, and its divide qualifier
//   flush_all           CP0 flush; wins over any stall
//   stall, bubble_e     freeze PC+F/D, clear D/E
//   md_busy             HI/LO unit busy
//   stall_cycles        saturating stall-cycle count (STALL_STATS_EN only)
// ---------------------------------------------------------------------------
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   // 2**CNT_W must exceed max(MULT_CYCLES, DIV_CYCLES)
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  dkind,
   input  logic [9:0]  ekind,
   input  logic [9:0]  mkind,
   input  logic [4:0]  d_reg1,
   input  logic [4:0]  d_reg2,
   input  logic [4:0]  e_regw,
   input  logic [4:0]  m_regw,
   input  logic        d_md,
   input  logic        e_md_start,
   input  logic        e_md_div,
   input  logic        flush_all,
   output logic        stall,
   output logic        bubble_e,
   output logic        md_busy
`ifdef STALL_STATS_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   dp_type_e   d_t, e_t, m_t;
   tuse_t      rs_use, rt_use;
   logic [1:0] e_new, m_new;
   logic       data_stall, md_stall;

   // Only the datapath type matters for hazards; the sub-op is ignored.
   logic       unused_subop;
   assign unused_subop = ^{dkind[4:0], ekind[4:0], mkind[4:0]};

   assign d_t = dp_type_e'(dkind[9:5]);
   assign e_t = dp_type_e'(ekind[9:5]);
   assign m_t = dp_type_e'(mkind[9:5]);

   assign rs_use = tuse_rs(d_t);
   assign rt_use = tuse_rt(d_t);
   assign e_new  = tnew_e(e_t);
   assign m_new  = tnew_m(m_t);

   assign data_stall = hazard(d_reg1, e_regw, rs_use, e_new)
                     | hazard(d_reg2, e_regw, rt_use, e_new)
                     | hazard(d_reg1, m_regw, rs_use, m_new)
                     | hazard(d_reg2, m_regw, rt_use, m_new);

   // The start cycle itself also blocks: HI/LO is stale from then on.
   assign md_stall = d_md & (md_busy | e_md_start);

   assign stall    = ~flush_all & (data_stall | md_stall);
   assign bubble_e = stall;

   md_busy_cnt #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_cnt (
      .clk   (clk),
      .reset (reset),
      .start (e_md_start),
      .div   (e_md_div),
      .flush (flush_all),
      .busy  (md_busy)
   );

`ifdef STALL_STATS_EN
   logic [31:0] stall_cycles_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_q <= stall_cycles_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;
   import stall_ctrl_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  dkind = '0, ekind = '0, mkind = '0;
   logic [4:0]  d_reg1 = '0, d_reg2 = '0, e_regw = '0, m_regw = '0;
   logic        d_md = 1'b0, e_md_start = 1'b0, e_md_div = 1'b0, flush_all = 1'b0;
   logic        stall, bubble_e, md_busy;
   logic [31:0] stall_cycles_w;

   stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .dkind      (dkind),
      .ekind      (ekind),
      .mkind      (mkind),
      .d_reg1     (d_reg1),
      .d_reg2     (d_reg2),
      .e_regw     (e_regw),
      .m_regw     (m_regw),
      .d_md       (d_md),
      .e_md_start (e_md_start),
      .e_md_div   (e_md_div),
      .flush_all  (flush_all),
      .stall      (stall),
      .bubble_e   (bubble_e),
      .md_busy    (md_busy)
`ifdef STALL_STATS_EN
      ,
      .stall_cycles (stall_cycles_w)
`endif
   );

`ifndef STALL_STATS_EN
   assign stall_cycles_w = '0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        busy;
      logic [31:0] sc;
      int          step;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: Tuse per register (-1 = not read), Tnew per stage.
   int rs_tu[32], rt_tu[32], tn_e[32], tn_m[32];
   int md_free_at = 0;  // first step index at which HI/LO is free again
   int step_k = 0;
   int stats = 0;

   function automatic bit haz(int tu, int tn, logic [4:0] src, logic [4:0] dst);
      return (tu >= 0) && (dst != 5'd0) && (dst == src) && (tn > tu);
   endfunction

   task automatic build_tables();
      for (int i = 0; i < 32; i++) begin
         rs_tu[i] = -1; rt_tu[i] = -1; tn_e[i] = 0; tn_m[i] = 0;
      end
      rs_tu[DT_BRANCH] = 0;  rt_tu[DT_BRANCH] = 0;
      rs_tu[DT_JUMP_R] = 0;  rt_tu[DT_JUMP_R] = 0;
      rs_tu[DT_CAL_R] = 1;   rs_tu[DT_CAL_I] = 1;  rs_tu[DT_LOAD_M] = 1;
      rs_tu[DT_STORE_M] = 1; rs_tu[DT_CMOV] = 1;
      rt_tu[DT_CAL_R] = 1;   rt_tu[DT_CMOV] = 1;
      rt_tu[DT_STORE_M] = 2; rt_tu[DT_STORE_C0] = 2;
      tn_e[DT_CAL_R] = 1;    tn_e[DT_CAL_I] = 1;
      tn_e[DT_LOAD_M] = 2;   tn_e[DT_LOAD_C0] = 2;
      tn_m[DT_LOAD_M] = 1;   tn_m[DT_LOAD_C0] = 1;
   endtask

   function automatic logic [9:0] kind(dp_type_e t);
      logic [4:0] sub;
      sub = 5'($urandom_range(0, 31));
      return {t, sub};
   endfunction

   // One cycle of stimulus: drive just after the edge, push the expectation.
   task automatic drive(input logic rst_v, input logic [9:0] dk, input logic [9:0] ek,
                        input logic [9:0] mk, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] ew, input logic [4:0] mw, input logic md,
                        input logic st, input logic dv, input logic fl);
      exp_t e;
      bit   busy, data, exp_stall;
      int   dt, et, mt;
      @(posedge clk);
      #1;
      reset = rst_v; dkind = dk; ekind = ek; mkind = mk;
      d_reg1 = r1; d_reg2 = r2; e_regw = ew; m_regw = mw;
      d_md = md; e_md_start = st; e_md_div = dv; flush_all = fl;

      if (rst_v) begin
         md_free_at = 0;
         stats = 0;
      end
      busy = (step_k < md_free_at);
      dt = int'(dk[9:5]); et = int'(ek[9:5]); mt = int'(mk[9:5]);
      data = haz(rs_tu[dt], tn_e[et], r1, ew) || haz(rt_tu[dt], tn_e[et], r2, ew) ||
             haz(rs_tu[dt], tn_m[mt], r1, mw) || haz(rt_tu[dt], tn_m[mt], r2, mw);
      exp_stall = !fl && (data || (md && (busy || st)));

      e.stall = exp_stall;
      e.busy  = busy;
      e.sc    = 32'(stats);
      e.step  = step_k;
      expq.push_back(e);

      // State seen after the next edge.
      if (!rst_v) begin
         if (st && !fl && !busy) md_free_at = step_k + 1 + (dv ? DIV_N : MULT_N);
         if (exp_stall) stats++;
      end
      step_k++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are checked every cycle on the falling edge.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         n_cmp++;
         if (stall !== e.stall) begin
            n_bad++;
            $display("FAIL stall step=%0d got=%b want=%b", e.step, stall, e.stall);
         end
         n_cmp++;
         if (bubble_e !== e.stall) begin
            n_bad++;
            $display("FAIL bubble_e step=%0d got=%b want=%b", e.step, bubble_e, e.stall);
         end
         n_cmp++;
         if (md_busy !== e.busy) begin
            n_bad++;
            $display("FAIL md_busy step=%0d got=%b want=%b", e.step, md_busy, e.busy);
         end
`ifdef STALL_STATS_EN
         n_cmp++;
         if (stall_cycles_w !== e.sc) begin
            n_bad++;
            $display("FAIL stall_cycles step=%0d got=%0d want=%0d", e.step, stall_cycles_w, e.sc);
         end
`endif
      end
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog timeout got=running want=finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      build_tables();
      drive(1'b1, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);

      // beq $3 behind lw $3: stalls with lw in E, then with lw in M.
      drive(1'b0, kind(DT_BRANCH), kind(DT_LOAD_M), '0, 5'd3, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, kind(DT_BRANCH), '0, kind(DT_LOAD_M), 5'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, kind(DT_BRANCH), '0, '0, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // addu after addu: forwardable.
      drive(1'b0, kind(DT_CAL_R), kind(DT_CAL_R), '0, 5'd4, 5'd2, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // sw rt after lw in M, then in E.
      drive(1'b0, kind(DT_STORE_M), '0, kind(DT_LOAD_M), 5'd0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, kind(DT_STORE_M), kind(DT_LOAD_M), '0, 5'd0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Writes to $0 never stall.
      drive(1'b0, kind(DT_BRANCH), kind(DT_LOAD_M), '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);

      // div start then mflo held: busy 10 cycles, stall 11.
      drive(1'b0, '0, kind(DT_NOP), '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++)
         drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      // Flush in the start cycle suppresses the load and the stall.
      drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      // mult, then a flush mid-count does not abort it.
      drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      // Reset mid-divide (count at 6) clears between edges.
      drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);

      // Randomized traffic over a small register set to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         logic [9:0] dk, ek, mk;
         dk = kind(dp_type_e'(5'($urandom_range(0, 12))));
         ek = kind(dp_type_e'(5'($urandom_range(0, 12))));
         mk = kind(dp_type_e'(5'($urandom_range(0, 12))));
         drive(($urandom_range(0, 299) == 0), dk, ek, mk,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end

      idle(1);
      @(negedge clk);
      #1;
      n_cmp++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain got=%0d want=0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
